// File: rtl/spi_ram_target_if.sv
// SPI target bus bundle: serial pins plus the target's status outputs.
interface spi_ram_target_if;
    logic spi_select;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic active;
    logic cmd_err;

    modport master (
        output spi_select, spi_clk, spi_mosi,
        input  spi_miso, active, cmd_err
    );

    modport slave (
        input  spi_select, spi_clk, spi_mosi,
        output spi_miso, active, cmd_err
    );
endinterface

// File: rtl/spi_ram_target.sv
// SPI mode-0 RAM target (READ 0x03 / WRITE 0x02), oversampled in the clk domain.
// Optional mode register (RDMR 0x05 / WRMR 0x01, byte mode) under SPI_RAM_TARGET_MODE_EN.
module spi_ram_target #(
    parameter int MEM_BITS  = 8,
    parameter int ADDR_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_ram_target_if.slave  bus
);
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
`ifdef SPI_RAM_TARGET_MODE_EN
    localparam logic [7:0] OP_RDMR  = 8'h05;
    localparam logic [7:0] OP_WRMR  = 8'h01;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_e;

    state_e                state_q;
    logic [1:0]            sel_sync_q, sclk_sync_q, mosi_sync_q;
    logic                  sel_prev_q, sclk_prev_q;
    logic [4:0]            bit_cnt_q;
    logic [MEM_BITS-1:0]   addr_q;
    logic [6:0]            rx_q;
    logic [7:0]            tx_q;
    logic                  is_write_q;
    logic                  reg_op_q;
    logic                  miso_q, active_q, cmd_err_q;
    logic                  wr_en_q;
    logic [MEM_BITS-1:0]   wr_addr_q;
    logic [7:0]            wr_data_q;
    logic [7:0]            mem_q [2**MEM_BITS];
`ifdef SPI_RAM_TARGET_MODE_EN
    logic [7:0]            mode_q;
`endif

    logic                  sel, mosi, sclk_rise, sclk_fall, sel_fall;
    logic [7:0]            rx_byte_d;
    logic [MEM_BITS-1:0]   addr_load_d, addr_next_d, step_d;

    assign sel       = sel_sync_q[1];
    assign mosi      = mosi_sync_q[1];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_prev_q;
    assign sel_fall  = ~sel & sel_prev_q;

    assign rx_byte_d   = {rx_q, mosi};
    // Shifting through a MEM_BITS-wide register drops upper address bits, so they alias.
    assign addr_load_d = {addr_q[MEM_BITS-2:0], mosi};
`ifdef SPI_RAM_TARGET_MODE_EN
    assign step_d      = (mode_q[7:6] == 2'b00) ? '0 : MEM_BITS'(1);
`else
    assign step_d      = MEM_BITS'(1);
`endif
    assign addr_next_d = addr_q + step_d;

    assign bus.spi_miso = miso_q;
    assign bus.active   = active_q;
    assign bus.cmd_err  = cmd_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_sync_q  <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sel_prev_q  <= 1'b0;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            is_write_q  <= 1'b0;
            reg_op_q    <= 1'b0;
            miso_q      <= 1'b0;
            active_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef SPI_RAM_TARGET_MODE_EN
            mode_q      <= 8'h40;
`endif
        end else begin
            sel_sync_q  <= {sel_sync_q[0],  bus.spi_select};
            sclk_sync_q <= {sclk_sync_q[0], bus.spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
            sel_prev_q  <= sel;
            sclk_prev_q <= sclk_sync_q[1];
            cmd_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;

            if (sel) begin
                state_q   <= IDLE;
                active_q  <= 1'b0;
                miso_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: if (sel_fall) begin
                        state_q    <= CMD;
                        bit_cnt_q  <= '0;
                        active_q   <= 1'b1;
                        is_write_q <= 1'b0;
                        reg_op_q   <= 1'b0;
                    end
                    CMD: if (sclk_rise) begin
                        rx_q      <= rx_byte_d[6:0];
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            case (rx_byte_d)
                                OP_READ:  state_q <= ADDR;
                                OP_WRITE: begin
                                    state_q    <= ADDR;
                                    is_write_q <= 1'b1;
                                end
`ifdef SPI_RAM_TARGET_MODE_EN
                                OP_RDMR: begin
                                    state_q  <= READ;
                                    reg_op_q <= 1'b1;
                                    tx_q     <= mode_q;
                                end
                                OP_WRMR: begin
                                    state_q  <= WRITE;
                                    reg_op_q <= 1'b1;
                                end
`endif
                                default: begin
                                    state_q   <= IGNORE;
                                    cmd_err_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ADDR: if (sclk_rise) begin
                        addr_q    <= addr_load_d;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (is_write_q) begin
                                state_q <= WRITE;
                            end else begin
                                // Preload so the MSB is ready for the very next falling edge.
                                state_q <= READ;
                                tx_q    <= mem_q[addr_load_d];
                            end
                        end
                    end
                    READ: if (sclk_fall) begin
                        miso_q <= tx_q[7];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
`ifdef SPI_RAM_TARGET_MODE_EN
                            if (reg_op_q) begin
                                tx_q <= mode_q;
                            end else begin
                                addr_q <= addr_next_d;
                                tx_q   <= mem_q[addr_next_d];
                            end
`else
                            addr_q <= addr_next_d;
                            tx_q   <= mem_q[addr_next_d];
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            tx_q      <= {tx_q[6:0], 1'b0};
                        end
                    end
                    WRITE: if (sclk_rise) begin
                        rx_q <= rx_byte_d[6:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
`ifdef SPI_RAM_TARGET_MODE_EN
                            if (reg_op_q) begin
                                mode_q <= rx_byte_d;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= rx_byte_d;
                                addr_q    <= addr_next_d;
                            end
`else
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= rx_byte_d;
                            addr_q    <= addr_next_d;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en_q) mem_q[wr_addr_q] <= wr_data_q;
    end
endmodule
